// File: rtl/uart_rx_if.sv
// Serial line, frame configuration and receive results for uart_rx.
interface uart_rx_if;
  logic       rx;
  logic [3:0] length;
  logic       parity_type;
  logic       parity_en;
  logic       stop2;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_err;
  logic       parity_err;
  logic       frame_err;
  logic       rx_busy;

  modport master (
    output rx, length, parity_type, parity_en, stop2,
    input  rx_data, rx_done, rx_err, parity_err, frame_err, rx_busy
  );

  modport slave (
    input  rx, length, parity_type, parity_en, stop2,
    output rx_data, rx_done, rx_err, parity_err, frame_err, rx_busy
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver sampling one bit per tx_clk edge (shares the transmitter's bit
// clock). Frame: start, 5..8 data bits LSB first, optional parity, 1 or 2 stops.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle; a 0 sample is the start bit, config is latched
// DATA      | collecting data bits into the holding register
// PARITY    | sampling the parity bit and recording any mismatch
// STOP1     | first stop bit; a 0 ends the frame with a framing error
// STOP2     | second stop bit (only when two stops were configured)
// WAIT_HIGH | after a framing error, wait for the line to return high
module uart_rx #(
  parameter int SYNC_STAGES = 0
) (
  input  logic      tx_clk,
  input  logic      rst,
  uart_rx_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP1, STOP2, WAIT_HIGH} state_t;

  state_t     state_q, state_n;
  logic [1:0] sync_q;
  logic       rx_s;
  logic [2:0] cnt_q, cnt_n;
  logic [2:0] last_q, last_n;
  logic       pen_q, pen_n;
  logic       ptype_q, ptype_n;
  logic       stop2_q, stop2_n;
  logic [7:0] shift_q, shift_n;
  logic       perr_pend_q, perr_pend_n;
  logic [7:0] data_q, data_n;
  logic       done_q, done_n;
  logic       err_q, err_n;
  logic       perr_q, perr_n;
  logic       ferr_q, ferr_n;
  logic       busy_q, busy_n;
  logic       finish;
  logic       ferr_f;
  logic       len_ok;

  // Optional rx synchroniser chain; resets to the idle (high) line level.
  always_ff @(posedge tx_clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], bus.rx};
  end

  // Pick the synchronised sample according to the configured depth.
  always_comb begin
    if (SYNC_STAGES == 0)      rx_s = bus.rx;
    else if (SYNC_STAGES == 1) rx_s = sync_q[0];
    else                       rx_s = sync_q[1];
  end

  // State, latched config, holding register and registered outputs.
  always_ff @(posedge tx_clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= 3'd7;
      pen_q       <= 1'b0;
      ptype_q     <= 1'b0;
      stop2_q     <= 1'b0;
      shift_q     <= '0;
      perr_pend_q <= 1'b0;
      data_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      last_q      <= last_n;
      pen_q       <= pen_n;
      ptype_q     <= ptype_n;
      stop2_q     <= stop2_n;
      shift_q     <= shift_n;
      perr_pend_q <= perr_pend_n;
      data_q      <= data_n;
      done_q      <= done_n;
      err_q       <= err_n;
      perr_q      <= perr_n;
      ferr_q      <= ferr_n;
      busy_q      <= busy_n;
    end
  end

  // Next-state and next-output logic; results commit on the finish edge.
  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    last_n      = last_q;
    pen_n       = pen_q;
    ptype_n     = ptype_q;
    stop2_n     = stop2_q;
    shift_n     = shift_q;
    perr_pend_n = perr_pend_q;
    data_n      = data_q;
    done_n      = 1'b0;
    err_n       = err_q;
    perr_n      = perr_q;
    ferr_n      = ferr_q;
    finish      = 1'b0;
    ferr_f      = 1'b0;
    len_ok      = (bus.length >= 4'd5) && (bus.length <= 4'd8);

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_n     = DATA;
          cnt_n       = '0;
          shift_n     = '0;
          perr_pend_n = 1'b0;
          pen_n       = bus.parity_en;
          ptype_n     = bus.parity_type;
          stop2_n     = bus.stop2;
          // length 8 (4'b1000) maps to index 7 via the 3-bit wrap, as do
          // out-of-range lengths through the fallback.
          last_n      = len_ok ? (bus.length[2:0] - 3'd1) : 3'd7;
        end
      end
      DATA: begin
        shift_n[cnt_q] = rx_s;
        cnt_n = cnt_q + 3'd1;
        if (cnt_q == last_q) begin
          cnt_n   = '0;
          state_n = pen_q ? PARITY : STOP1;
        end
      end
      PARITY: begin
        // Upper unused bits are zero, so the full-width reduction is exact.
        perr_pend_n = rx_s != ((^shift_q) ^ ~ptype_q);
        state_n     = STOP1;
      end
      STOP1: begin
        if (!rx_s) begin
          finish = 1'b1;
          ferr_f = 1'b1;
        end else if (stop2_q) begin
          state_n = STOP2;
        end else begin
          finish = 1'b1;
        end
      end
      STOP2: begin
        finish = 1'b1;
        ferr_f = !rx_s;
      end
      WAIT_HIGH: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (finish) begin
      data_n  = shift_q;
      perr_n  = perr_pend_q;
      ferr_n  = ferr_f;
      err_n   = perr_pend_q | ferr_f;
      done_n  = 1'b1;
      state_n = ferr_f ? WAIT_HIGH : IDLE;
    end

    busy_n = (state_n != IDLE);
  end

  assign bus.rx_data    = data_q;
  assign bus.rx_done    = done_q;
  assign bus.rx_err     = err_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.rx_busy    = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: the driver serialises frames from a simple
// frame model and queues the expected result; a monitor checks each rx_done.
module tb_uart_rx;

  logic tx_clk = 1'b0;
  logic rst;
  uart_rx_if bus();

  uart_rx #(.SYNC_STAGES(0)) dut (
    .tx_clk (tx_clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 tx_clk = ~tx_clk;

  int cyc = 0;
  always @(posedge tx_clk) cyc++;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         when;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  exp_t me;
  always @(negedge tx_clk) begin
    if (bus.rx_done === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: rx_done with empty scoreboard, rx_data=%0h expected none (cycle %0d)",
                 bus.rx_data, cyc);
      end else begin
        me = sb.pop_front();
        check("rx_data",    bus.rx_data,    me.data);
        check("parity_err", bus.parity_err, me.perr);
        check("frame_err",  bus.frame_err,  me.ferr);
        check("rx_err",     bus.rx_err,     me.perr | me.ferr);
        check("done_cycle", cyc,            me.when);
      end
    end
  end

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge tx_clk);
      bus.rx = 1'b1;
    end
  endtask

  // Builds the sample sequence up to the finish bit, then drives it.
  task automatic send_frame(input logic [7:0] d, input logic [3:0] len, input logic pen,
                            input logic ptype, input logic st2, input logic flip,
                            input logic s1, input logic s2, input int chg_at,
                            input logic [3:0] chg_len);
    int         n;
    logic [7:0] dm;
    logic       pbit;
    logic       ferr;
    logic       bits[$];
    exp_t       e;
    n    = (len >= 5 && len <= 8) ? int'(len) : 8;
    dm   = d & (8'hFF >> (8 - n));
    ferr = !s1 || (st2 && !s2);
    bits.push_back(1'b0);
    for (int i = 0; i < n; i++) bits.push_back(d[i]);
    if (pen) begin
      pbit = ($countones(dm) % 2 == 1) ? ptype : !ptype;
      bits.push_back(pbit ^ flip);
    end
    bits.push_back(s1);
    if (s1 && st2) bits.push_back(s2);
    e.data = dm;
    e.perr = pen & flip;
    e.ferr = ferr;

    @(negedge tx_clk);
    bus.rx          = 1'b0;
    bus.length      = len;
    bus.parity_en   = pen;
    bus.parity_type = ptype;
    bus.stop2       = st2;
    e.when = cyc + bits.size();
    sb.push_back(e);
    for (int i = 1; i < bits.size(); i++) begin
      @(negedge tx_clk);
      if (i == 1) check("busy_in_frame", bus.rx_busy, 1);
      if (i == chg_at) bus.length = chg_len;
      bus.rx = bits[i];
    end
    if (ferr) begin
      @(negedge tx_clk);
      bus.rx = 1'b1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_data"},    bus.rx_data,    0);
    check({tag, "_rx_done"},    bus.rx_done,    0);
    check({tag, "_rx_err"},     bus.rx_err,     0);
    check({tag, "_parity_err"}, bus.parity_err, 0);
    check({tag, "_frame_err"},  bus.frame_err,  0);
    check({tag, "_rx_busy"},    bus.rx_busy,    0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t eb;
    bus.rx          = 1'b1;
    bus.length      = 4'd8;
    bus.parity_en   = 1'b0;
    bus.parity_type = 1'b0;
    bus.stop2       = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge tx_clk);
    check_all_zero("reset");
    rst = 1'b0;
    idle(2);

    // 8N1 0xA5
    send_frame(8'hA5, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1, 4'd0);
    idle(3);

    // length 5, odd parity type, good then forced-bad parity bit
    send_frame(8'h13, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, -1, 4'd0);
    idle(2);
    send_frame(8'h13, 4'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, -1, 4'd0);
    idle(4);
    check("hold_rx_data",    bus.rx_data,    8'h13);
    check("hold_parity_err", bus.parity_err, 1);
    check("hold_rx_err",     bus.rx_err,     1);

    // back-to-back 7-bit frames, parity, two stop bits (11 bits each)
    send_frame(8'h55, 4'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, -1, 4'd0);
    send_frame(8'h2A, 4'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, -1, 4'd0);
    idle(3);

    // break: line low for 20 cycles in 8N1
    @(negedge tx_clk);
    bus.rx = 1'b0; bus.length = 4'd8; bus.parity_en = 1'b0; bus.stop2 = 1'b0;
    eb.data = 8'h00; eb.perr = 1'b0; eb.ferr = 1'b1; eb.when = cyc + 10;
    sb.push_back(eb);
    for (int i = 1; i < 20; i++) begin
      @(negedge tx_clk);
      if (i >= 11) check("busy_wait_high", bus.rx_busy, 1);
      bus.rx = 1'b0;
    end
    @(negedge tx_clk);
    bus.rx = 1'b1;
    @(negedge tx_clk);
    check("busy_after_break", bus.rx_busy, 0);
    send_frame(8'h3C, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1, 4'd0);
    idle(2);

    // reset at E4 of a 0xF0 frame
    @(negedge tx_clk); bus.rx = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge tx_clk); bus.rx = 1'b0;
    end
    @(negedge tx_clk); rst = 1'b1;
    @(negedge tx_clk);
    check_all_zero("midreset");
    rst = 1'b0;
    bus.rx = 1'b1;
    idle(2);
    send_frame(8'hF0, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1, 4'd0);
    idle(2);

    // length changed 8 -> 5 at E3; frame still 8 bits, next frame 5 bits
    send_frame(8'hC7, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3, 4'd5);
    idle(1);
    send_frame(8'hFF, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1, 4'd0);
    idle(2);

    // randomized frames, including invalid lengths and corrupted bits
    for (int f = 0; f < 40; f++) begin
      logic [7:0] rd;
      logic [3:0] rl;
      int         ca;
      rd = 8'($urandom);
      rl = 4'($urandom_range(0, 15));
      ca = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : -1;
      send_frame(rd, rl, 1'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) != 0),
                 ($urandom_range(0, 5) != 0), ca, 4'($urandom_range(0, 15)));
      idle($urandom_range(0, 2));
    end

    idle(20);
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
